alu_issue: RTL and testbench

- Operand-issue stage: the producer end of the ALU's alu_src0/alu_src1/alu_op interface.
- Accepts one decoded-stage beat (instruction, PC, register-file read data), decodes RV32I into ALU opcode and operand selection, and registers the result.
- Sits between register read and the ALU.
- Valid/ready handshake on both sides, plus a pipeline flush.

---
 rtl/alu_issue.sv | 185 ++++++++++++++++++
 tb/tb_alu_issue.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue.sv
// alu_issue: RV32I operand-issue stage feeding alu_src0/alu_src1/alu_op with a valid/ready handshake.
// Optional macro ALU_ISSUE_SKID_EN adds a one-entry skid buffer and a registered in_ready.
module alu_issue #(
   parameter int XLEN = 32,
   parameter int OP_W = 5
) (
   input  logic            clk,
   input  logic            rstn,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [31:0]     in_inst,
   input  logic [XLEN-1:0] in_pc,
   input  logic [XLEN-1:0] in_rs1_data,
   input  logic [XLEN-1:0] in_rs2_data,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] alu_src0,
   output logic [XLEN-1:0] alu_src1,
   output logic [OP_W-1:0] alu_op,
   output logic [4:0]      out_rd,
   output logic            out_wen,
   output logic [XLEN-1:0] out_pc,
   output logic            out_illegal
);
   localparam logic [OP_W-1:0] OP_ADD  = 5'b00000;
   localparam logic [OP_W-1:0] OP_SUB  = 5'b00010;
   localparam logic [OP_W-1:0] OP_SLT  = 5'b00100;
   localparam logic [OP_W-1:0] OP_SLTU = 5'b00101;
   localparam logic [OP_W-1:0] OP_AND  = 5'b01001;
   localparam logic [OP_W-1:0] OP_OR   = 5'b01010;
   localparam logic [OP_W-1:0] OP_XOR  = 5'b01011;
   localparam logic [OP_W-1:0] OP_SLL  = 5'b01110;
   localparam logic [OP_W-1:0] OP_SRL  = 5'b01111;
   localparam logic [OP_W-1:0] OP_SRA  = 5'b10000;
   localparam logic [OP_W-1:0] OP_SRC1 = 5'b10010;

   typedef struct packed {
      logic [XLEN-1:0] src0;
      logic [XLEN-1:0] src1;
      logic [XLEN-1:0] pc;
      logic [OP_W-1:0] op;
      logic [4:0]      rd;
      logic            wen;
      logic            ill;
   } beat_t;

   beat_t dec, out_q;
   logic [6:0] opc, f7;
   logic [2:0] f3;
   logic alt, shift, bad_sh;
   logic [XLEN-1:0] imm_i, imm_s, imm_u;

   assign opc    = in_inst[6:0];
   assign f3     = in_inst[14:12];
   assign f7     = in_inst[31:25];
   assign alt    = f7 == 7'b0100000;
   assign shift  = f3[1:0] == 2'b01;
   assign bad_sh = shift && f7 != 7'b0 && !(f3 == 3'b101 && alt);
   assign imm_i  = {{20{in_inst[31]}}, in_inst[31:20]};
   assign imm_s  = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
   assign imm_u  = {in_inst[31:12], 12'b0};

   function automatic logic [OP_W-1:0] fn_op(input logic [2:0] f, input logic a);
      case (f)
         3'b000:  fn_op = a ? OP_SUB : OP_ADD;
         3'b001:  fn_op = OP_SLL;
         3'b010:  fn_op = OP_SLT;
         3'b011:  fn_op = OP_SLTU;
         3'b100:  fn_op = OP_XOR;
         3'b101:  fn_op = a ? OP_SRA : OP_SRL;
         3'b110:  fn_op = OP_OR;
         default: fn_op = OP_AND;
      endcase
   endfunction

   // decode the incoming instruction into ALU opcode, operands and writeback control
   always_comb begin
      dec = '0;
      dec.pc = in_pc;
      dec.rd = in_inst[11:7];
      dec.wen = 1'b1;
      case (opc)
         7'b0110011: begin
            dec.src0 = in_rs1_data;
            dec.src1 = in_rs2_data;
            dec.op = fn_op(f3, alt);
         end
         7'b0010011: begin
            dec.src0 = in_rs1_data;
            dec.src1 = shift ? {27'b0, in_inst[24:20]} : imm_i;
            dec.op = fn_op(f3, alt && f3 != 3'b000);
            dec.ill = bad_sh;
         end
         7'b0110111: begin
            dec.op = OP_SRC1;
            dec.src1 = imm_u;
         end
         7'b0010111: begin
            dec.src0 = in_pc;
            dec.src1 = imm_u;
         end
         7'b1101111, 7'b1100111: begin
            dec.src0 = in_pc;
            dec.src1 = 'd4;
         end
         7'b0000011: begin
            dec.src0 = in_rs1_data;
            dec.src1 = imm_i;
         end
         7'b0100011: begin
            dec.src0 = in_rs1_data;
            dec.src1 = imm_s;
            dec.wen = 1'b0;
         end
         7'b1100011: begin
            dec.op = OP_SUB;
            dec.src0 = in_rs1_data;
            dec.src1 = in_rs2_data;
            dec.wen = 1'b0;
         end
         default: dec.ill = 1'b1;
      endcase
      if (dec.ill) begin
         dec.op = OP_ADD;
         dec.src0 = '0;
         dec.src1 = '0;
      end
      dec.wen = dec.wen && !dec.ill && in_inst[11:7] != 5'd0;
   end

   assign alu_src0    = out_q.src0;
   assign alu_src1    = out_q.src1;
   assign alu_op      = out_q.op;
   assign out_rd      = out_q.rd;
   assign out_wen     = out_q.wen;
   assign out_pc      = out_q.pc;
   assign out_illegal = out_q.ill;

`ifdef ALU_ISSUE_SKID_EN
   beat_t skid_q;
   logic  skid_valid;

   assign in_ready = rstn & !skid_valid;

   // output register fed from the skid entry first so beat order is preserved
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         out_valid  <= 1'b0;
         skid_valid <= 1'b0;
         out_q      <= '0;
         skid_q     <= '0;
      end else if (flush) begin
         out_valid  <= 1'b0;
         skid_valid <= 1'b0;
      end else if (!out_valid || out_ready) begin
         out_valid  <= skid_valid || in_valid;
         skid_valid <= 1'b0;
         if (skid_valid) out_q <= skid_q;
         else if (in_valid) out_q <= dec;
      end else if (in_valid && !skid_valid) begin
         skid_q     <= dec;
         skid_valid <= 1'b1;
      end
   end
`else
   logic rdy;

   assign rdy      = !out_valid || out_ready;
   assign in_ready = rstn & rdy;

   // single output register; a new beat loads whenever the slot is free
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         out_valid <= 1'b0;
         out_q     <= '0;
      end else if (flush) begin
         out_valid <= 1'b0;
      end else if (rdy) begin
         out_valid <= in_valid;
         if (in_valid) out_q <= dec;
      end
   end
`endif
endmodule

// File: tb/tb_alu_issue.sv
// tb_alu_issue: directed and random checks of alu_issue against a queue-based instruction-level model.
module tb_alu_issue;
   logic clk = 1'b0, rstn = 1'b1, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
   logic [31:0] in_inst = '0, in_pc = '0, in_rs1_data = '0, in_rs2_data = '0;
   logic in_ready, out_valid, out_wen, out_illegal;
   logic [31:0] alu_src0, alu_src1, out_pc;
   logic [4:0] alu_op, out_rd;
   int vectors = 0, miscompares = 0;

   localparam logic [4:0] A_ADD = 5'd0, A_SUB = 5'd2, A_SLT = 5'd4, A_SLTU = 5'd5;
   localparam logic [4:0] A_AND = 5'd9, A_OR = 5'd10, A_XOR = 5'd11;
   localparam logic [4:0] A_SLL = 5'd14, A_SRL = 5'd15, A_SRA = 5'd16, A_SRC1 = 5'd18;

   typedef struct {
      logic [4:0]  op;
      logic [31:0] s0;
      logic [31:0] s1;
      logic [31:0] pc;
      logic [4:0]  rd;
      logic        wen;
      logic        ill;
   } exp_t;

   exp_t q[$];

   alu_issue dut (
      .clk(clk), .rstn(rstn), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
      .in_inst(in_inst), .in_pc(in_pc), .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data),
      .out_valid(out_valid), .out_ready(out_ready), .alu_src0(alu_src0), .alu_src1(alu_src1),
      .alu_op(alu_op), .out_rd(out_rd), .out_wen(out_wen), .out_pc(out_pc), .out_illegal(out_illegal)
   );

   always #5 clk = ~clk;

   function automatic exp_t ref_model(input logic [31:0] i, input logic [31:0] pc, input logic [31:0] r1, input logic [31:0] r2);
      logic [4:0] fn [8];
      int f3;
      logic sub7, sh;
      logic [31:0] imm_i, imm_s, imm_u;
      exp_t e;
      fn = '{A_ADD, A_SLL, A_SLT, A_SLTU, A_XOR, A_SRL, A_OR, A_AND};
      f3 = int'(i[14:12]);
      sub7 = i[31:25] == 7'h20;
      imm_i = 32'($signed(i) >>> 20);
      imm_s = (imm_i & ~32'h1F) | 32'(i[11:7]);
      imm_u = i & 32'hFFFFF000;
      e = '{op: A_ADD, s0: 32'h0, s1: 32'h0, pc: pc, rd: i[11:7], wen: 1'b1, ill: 1'b0};
      case (i[6:0])
         7'h33: begin
            e.s0 = r1;
            e.s1 = r2;
            e.op = (sub7 && f3 == 0) ? A_SUB : (sub7 && f3 == 5) ? A_SRA : fn[f3];
         end
         7'h13: begin
            sh = f3 == 1 || f3 == 5;
            if (sh && !(i[31:25] == 7'h0 || (f3 == 5 && sub7))) e.ill = 1'b1;
            else begin
               e.s0 = r1;
               e.s1 = sh ? 32'(i[24:20]) : imm_i;
               e.op = (f3 == 5 && sub7) ? A_SRA : fn[f3];
            end
         end
         7'h37: begin e.op = A_SRC1; e.s1 = imm_u; end
         7'h17: begin e.s0 = pc; e.s1 = imm_u; end
         7'h6F, 7'h67: begin e.s0 = pc; e.s1 = 32'd4; end
         7'h03: begin e.s0 = r1; e.s1 = imm_i; end
         7'h23: begin e.s0 = r1; e.s1 = imm_s; e.wen = 1'b0; end
         7'h63: begin e.op = A_SUB; e.s0 = r1; e.s1 = r2; e.wen = 1'b0; end
         default: e.ill = 1'b1;
      endcase
      if (e.ill || e.rd == 5'd0) e.wen = 1'b0;
      return e;
   endfunction

   function automatic logic [31:0] rand_inst();
      logic [6:0] opcs [11];
      logic [31:0] i;
      opcs = '{7'h33, 7'h13, 7'h37, 7'h17, 7'h6F, 7'h67, 7'h03, 7'h23, 7'h63, 7'h7F, 7'h0F};
      i = $urandom;
      i[6:0] = opcs[$urandom_range(0, 10)];
      if ($urandom_range(0, 7) == 0) i[11:7] = 5'd0;
      if (i[6:0] == 7'h33)
         i[31:25] = ((i[14:12] == 3'd0 || i[14:12] == 3'd5) && $urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
      if (i[6:0] == 7'h13 && i[13:12] == 2'b01) begin
         case ($urandom_range(0, 2))
            0: i[31:25] = 7'h00;
            1: i[31:25] = 7'h20;
            default: ;
         endcase
         if (i[14:12] == 3'd1 && i[31:25] == 7'h20) i[31:25] = 7'h21;
      end
      return i;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic check_out();
      chk("out_valid", 32'(out_valid), 32'(q.size() > 0));
      if (q.size() > 0) begin
         chk("alu_op", 32'(alu_op), 32'(q[0].op));
         chk("alu_src0", alu_src0, q[0].s0);
         chk("alu_src1", alu_src1, q[0].s1);
         chk("out_rd", 32'(out_rd), 32'(q[0].rd));
         chk("out_wen", 32'(out_wen), 32'(q[0].wen));
         chk("out_pc", out_pc, q[0].pc);
         chk("out_illegal", 32'(out_illegal), 32'(q[0].ill));
      end
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_in_ready"}, 32'(in_ready), 32'h0);
      chk({tag, "_out_valid"}, 32'(out_valid), 32'h0);
      chk({tag, "_alu_op"}, 32'(alu_op), 32'h0);
      chk({tag, "_src0"}, alu_src0, 32'h0);
      chk({tag, "_src1"}, alu_src1, 32'h0);
      chk({tag, "_rd"}, 32'(out_rd), 32'h0);
      chk({tag, "_wen"}, 32'(out_wen), 32'h0);
      chk({tag, "_pc"}, out_pc, 32'h0);
      chk({tag, "_illegal"}, 32'(out_illegal), 32'h0);
   endtask

   task automatic cycle(input logic v, input logic [31:0] i, input logic [31:0] pc, input logic [31:0] r1,
                        input logic [31:0] r2, input logic rdy, input logic fl);
      logic exp_rdy;
      in_valid = v;
      in_inst = i;
      in_pc = pc;
      in_rs1_data = r1;
      in_rs2_data = r2;
      out_ready = rdy;
      flush = fl;
      exp_rdy = q.size() == 0 || rdy;
      #1 chk("in_ready", 32'(in_ready), 32'(exp_rdy));
      @(posedge clk);
      if (fl) q.delete();
      else begin
         if (q.size() > 0 && rdy) void'(q.pop_front());
         if (v && exp_rdy) q.push_back(ref_model(i, pc, r1, r2));
      end
      @(negedge clk);
      check_out();
   endtask

   initial begin
      #2 rstn = 1'b0;
      #1 chk_zero("reset");
      @(negedge clk);
      @(negedge clk);
      rstn = 1'b1;
      #1 chk("ready_after_reset", 32'(in_ready), 32'h1);

      cycle(1'b1, 32'h002081B3, 32'h100, 32'd5, 32'd7, 1'b1, 1'b0);
      chk("add_valid", 32'(out_valid), 32'h1);
      chk("add_op", 32'(alu_op), 32'h0);
      chk("add_src0", alu_src0, 32'd5);
      chk("add_src1", alu_src1, 32'd7);
      chk("add_rd", 32'(out_rd), 32'd3);
      chk("add_wen", 32'(out_wen), 32'h1);
      cycle(1'b1, 32'h402081B3, 32'h104, 32'd5, 32'd7, 1'b1, 1'b0);
      chk("sub_op", 32'(alu_op), 32'h2);
      cycle(1'b1, 32'h40335293, 32'h108, 32'h80000000, 32'h0, 1'b1, 1'b0);
      chk("srai_op", 32'(alu_op), 32'h10);
      chk("srai_src0", alu_src0, 32'h80000000);
      chk("srai_src1", alu_src1, 32'd3);
      chk("srai_rd", 32'(out_rd), 32'd5);
      cycle(1'b1, 32'h123450B7, 32'h10C, 32'h0, 32'h0, 1'b1, 1'b0);
      chk("lui_op", 32'(alu_op), 32'h12);
      chk("lui_src1", alu_src1, 32'h12345000);
      chk("lui_rd", 32'(out_rd), 32'd1);
      cycle(1'b1, 32'h00001117, 32'h80000000, 32'h0, 32'h0, 1'b1, 1'b0);
      chk("auipc_op", 32'(alu_op), 32'h0);
      chk("auipc_src0", alu_src0, 32'h80000000);
      chk("auipc_src1", alu_src1, 32'h00001000);
      cycle(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0);
      chk("drop_valid", 32'(out_valid), 32'h0);

      cycle(1'b1, 32'h00A00093, 32'h200, 32'h0, 32'h0, 1'b1, 1'b0);
      for (int k = 0; k < 3; k++) begin
         cycle(1'b1, 32'h00208133, 32'h204, 32'd1, 32'd2, 1'b0, 1'b0);
         chk("stall_ready", 32'(in_ready), 32'h0);
         chk("stall_src1", alu_src1, 32'd10);
      end
      cycle(1'b1, 32'h00208133, 32'h204, 32'd1, 32'd2, 1'b1, 1'b1);
      chk("flush_valid", 32'(out_valid), 32'h0);
      cycle(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0);
      chk("flush_dropped", 32'(out_valid), 32'h0);

      cycle(1'b1, 32'hFFFFFFFF, 32'h300, 32'h1, 32'h2, 1'b1, 1'b0);
      chk("illegal_flag", 32'(out_illegal), 32'h1);
      chk("illegal_wen", 32'(out_wen), 32'h0);
      cycle(1'b1, 32'h00100013, 32'h304, 32'h0, 32'h0, 1'b1, 1'b0);
      chk("x0_wen", 32'(out_wen), 32'h0);

      repeat (400)
         cycle($urandom_range(0, 3) != 0, rand_inst(), $urandom, $urandom, $urandom,
               $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0);

      cycle(1'b1, 32'h00A00093, 32'h400, 32'h0, 32'h0, 1'b1, 1'b0);
      cycle(1'b1, 32'h00208133, 32'h404, 32'd1, 32'd2, 1'b0, 1'b0);
      in_valid = 1'b0;
      #2 rstn = 1'b0;
      #1 chk_zero("midreset");
      q.delete();
      @(negedge clk);
      rstn = 1'b1;
      #1 chk("ready_after_midreset", 32'(in_ready), 32'h1);
      cycle(1'b1, 32'h002081B3, 32'h500, 32'd9, 32'd4, 1'b1, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
